screen_mem_arbiter: RTL and testbench

Time-slices the single-port 6912-byte Spectrum screen RAM between the raster video generator and the Z80 CPU. Sits directly upstream of the video block and supplies its bitmap byte (`vga_data`) and attribute byte (`attr_data`) from the addresses it presents. All remaining RAM bandwidth goes to CPU reads and writes through a req/ack handshake. An optional ULA-style contention mode starves the CPU during active display.

---
 rtl/screen_pkg.sv | 33 +++
 rtl/screen_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_screen_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/screen_pkg.sv
// screen_pkg -- shared definitions for the Spectrum screen RAM arbiter.
//
// Holds the 4-phase slot encoding, screen geometry constants and a helper
// that advances the slot phase with wrap-around.
//
// Optional build macro used by screen_mem_arbiter: SCREEN_CONTENTION_EN.
package screen_pkg;

  localparam int          SCREEN_ADDR_W = 13;
  localparam int          SCREEN_BYTES  = 6912;
  localparam logic [12:0] ATTR_BASE     = 13'h1800;

  // One RAM access per clock; the four clocks of a frame are fixed slots.
  typedef enum logic [1:0] {
    PH_BMP   = 2'd0,  // video bitmap fetch
    PH_ATTR  = 2'd1,  // video attribute fetch
    PH_CPU_A = 2'd2,  // first CPU slot
    PH_CPU_B = 2'd3   // second CPU slot
  } slot_e;

  // Next slot in the frame, wrapping CPU_B back to BMP.
  function automatic slot_e next_slot(input slot_e s);
    slot_e n;
    case (s)
      PH_BMP:   n = PH_ATTR;
      PH_ATTR:  n = PH_CPU_A;
      PH_CPU_A: n = PH_CPU_B;
      default:  n = PH_BMP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/screen_mem_arbiter.sv
// screen_mem_arbiter -- time-slices the single-port screen RAM between the
// raster video generator and the Z80 CPU.
//
// Slot schedule (one RAM access per clock):
//   ph0 BMP   : read vid_addr,  byte lands in vga_data at end of ph1
//   ph1 ATTR  : read attr_addr, byte lands in attr_data at end of ph2
//   ph2/ph3   : CPU slots, granted to a pending cpu_req when idle
// A CPU access granted in cycle S returns read data at the end of S+1 and
// pulses cpu_ack during S+2. vid_sync realigns the phase to ph0.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   vid_sync, vid_active    video line realign pulse, active-display flag
//   vid_addr, attr_addr     video bitmap/attribute addresses
//   vga_data, attr_data     registered video bytes
//   cpu_req/we/addr/din     CPU request (level, held until cpu_ack)
//   cpu_dout, cpu_ack       CPU read data and one-cycle completion pulse
//   ram_addr/we/din/dout    synchronous single-port RAM (1-cycle read latency)
//
// Build macro: SCREEN_CONTENTION_EN -- when defined, CPU slots are withheld
// while vid_active is high (ULA-style contention). When undefined, vid_active
// is ignored.
module screen_mem_arbiter
  import screen_pkg::*;
#(
  parameter int ADDR_W = SCREEN_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_sync,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] attr_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic [DATA_W-1:0] attr_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  slot_e             r_ph;
  logic              r_s1_valid;   // an access was granted last cycle (S+1)
  logic              r_s1_rd;      // ... and it was a read
  logic              r_ack;        // S+2 completion pulse
  logic [DATA_W-1:0] r_cpu_dout;
  logic [DATA_W-1:0] r_vga;
  logic [DATA_W-1:0] r_attr;

  logic              w_busy;
  logic              w_cpu_slot;
  logic              w_contend;
  logic              w_grant;

  // Busy spans S+1 and S+2 so the CPU_B slot right after a CPU_A grant
  // cannot serve the same held request a second time.
  assign w_busy     = r_s1_valid | r_ack;
  assign w_cpu_slot = (r_ph == PH_CPU_A) || (r_ph == PH_CPU_B);

`ifdef SCREEN_CONTENTION_EN
  assign w_contend = vid_active;
`else
  logic w_unused_vid_active;
  assign w_unused_vid_active = vid_active;
  assign w_contend           = 1'b0;
`endif

  // Reset blocks the grant so no RAM write can slip out while resetting.
  assign w_grant = w_cpu_slot & cpu_req & ~w_busy & ~w_contend & ~reset;

  // RAM port mux. Ungranted CPU slots park on vid_addr as a harmless read.
  always_comb begin
    ram_addr = vid_addr;
    ram_we   = 1'b0;
    ram_din  = cpu_din;
    case (r_ph)
      PH_BMP:  ram_addr = vid_addr;
      PH_ATTR: ram_addr = attr_addr;
      default: begin
        if (w_grant) begin
          ram_addr = cpu_addr;
          ram_we   = cpu_we;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph       <= PH_BMP;
      r_s1_valid <= 1'b0;
      r_s1_rd    <= 1'b0;
      r_ack      <= 1'b0;
      r_cpu_dout <= '0;
      r_vga      <= '0;
      r_attr     <= '0;
    end else begin
      r_ph       <= vid_sync ? PH_BMP : next_slot(r_ph);
      // The CPU pipeline runs on its own and ignores vid_sync.
      r_s1_valid <= w_grant;
      r_s1_rd    <= w_grant & ~cpu_we;
      r_ack      <= r_s1_valid;
      if (r_s1_valid && r_s1_rd) begin
        r_cpu_dout <= ram_dout;
      end
      // ram_dout during ph1 holds the ph0 bitmap read; during ph2 the ph1
      // attribute read.
      if (r_ph == PH_ATTR) begin
        r_vga <= ram_dout;
      end
      if (r_ph == PH_CPU_A) begin
        r_attr <= ram_dout;
      end
    end
  end

  assign vga_data  = r_vga;
  assign attr_data = r_attr;
  assign cpu_dout  = r_cpu_dout;
  assign cpu_ack   = r_ack;

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Behavioural single-port RAM (1-cycle read latency, write-first) plus the
// directed bench for screen_mem_arbiter. Define SCREEN_CONTENTION_EN for
// both RTL and bench to exercise contention mode.
module screen_ram_sp #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout <= mem[addr];
    end
  end
endmodule

module tb_screen_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_sync;
  logic        vid_active;
  logic [12:0] vid_addr;
  logic [12:0] attr_addr;
  logic [7:0]  vga_data;
  logic [7:0]  attr_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  int          n_cmp = 0;
  int          n_err = 0;
  int          acks;
  int          wes;
  logic [1:0]  tb_ph = 2'd0;   // bench's own model of the slot phase

  always #5 clk = ~clk;

  screen_mem_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .vid_sync(vid_sync), .vid_active(vid_active),
    .vid_addr(vid_addr), .attr_addr(attr_addr),
    .vga_data(vga_data), .attr_data(attr_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  screen_ram_sp #(.AW(13), .DW(8)) u_ram (
    .clk(clk), .addr(ram_addr), .we(ram_we), .din(ram_din), .dout(ram_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 2 time units after the edge.
  task automatic step();
    if (reset || vid_sync) tb_ph = 2'd0;
    else                   tb_ph = tb_ph + 2'd1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; vid_sync = 1'b0; vid_active = 1'b0;
    vid_addr = 13'h0000; attr_addr = 13'h1800;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    #1;
    for (int i = 0; i < 8192; i++) u_ram.mem[i] = 8'h00;
    u_ram.mem[13'h0000] = 8'hA5;
    u_ram.mem[13'h1800] = 8'h47;
    u_ram.mem[13'h0020] = 8'h5A;

    repeat (3) step();
    #1;
    chk("rst_ph",        32'(dut.r_ph), 32'd0);
    chk("rst_vga",       32'(vga_data), 32'h00);
    chk("rst_attr",      32'(attr_data), 32'h00);
    chk("rst_ack",       32'(cpu_ack), 32'd0);
    chk("rst_dout",      32'(cpu_dout), 32'h00);
    chk("rst_ram_we",    32'(ram_we), 32'd0);

    // c0 ph0 / c1 ph1: video fetch addresses
    reset = 1'b0; #1;
    chk("c0_bmp_addr",   32'(ram_addr), 32'h0000);
    step(); #1;
    chk("c1_attr_addr",  32'(ram_addr), 32'h1800);
    step(); #1;
    chk("c2_vga",        32'(vga_data), 32'hA5);
    step(); #1;
    chk("c3_attr",       32'(attr_data), 32'h47);
    chk("c3_vga_hold",   32'(vga_data), 32'hA5);
    step();                                   // c4 ph0
    step();                                   // c5 ph1: raise write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_din = 8'h3C; #1;
    chk("wr_ph1_we",     32'(ram_we), 32'd0);
    step(); #1;                               // c6 ph2 grant
    chk("wr_grant_we",   32'(ram_we), 32'd1);
    chk("wr_grant_addr", 32'(ram_addr), 32'h0010);
    chk("wr_grant_din",  32'(ram_din), 32'h3C);
    chk("wr_s_ack",      32'(cpu_ack), 32'd0);
    step(); #1;                               // c7 ph3 busy
    chk("wr_busy_we",    32'(ram_we), 32'd0);
    chk("wr_s1_ack",     32'(cpu_ack), 32'd0);
    step(); #1;                               // c8 ph0 ack
    chk("wr_ack",        32'(cpu_ack), 32'd1);
    chk("wr_dout_keep",  32'(cpu_dout), 32'h00);
    step();                                   // c9 ph1: switch to read
    cpu_we = 1'b0; #1;
    chk("rd_pre_ack",    32'(cpu_ack), 32'd0);
    step(); #1;                               // c10 ph2 grant
    chk("rd_grant_addr", 32'(ram_addr), 32'h0010);
    chk("rd_grant_we",   32'(ram_we), 32'd0);
    step(); #1;                               // c11 ph3
    chk("rd_no_rewrite", 32'(ram_we), 32'd0);
    step(); #1;                               // c12 ph0
    chk("rd_ack",        32'(cpu_ack), 32'd1);
    chk("rd_dout",       32'(cpu_dout), 32'h3C);

    // Held read request: one ack per 4-clock frame, never a write.
    acks = 0; wes = 0;
    for (int i = 0; i < 16; i++) begin
      step(); #1;
      if (cpu_ack) acks++;
      if (ram_we)  wes++;
    end
    chk("held_acks",     32'(acks), 32'd4);
    chk("held_writes",   32'(wes), 32'd0);

    // vid_sync during a CPU_A read grant.
    step();                                   // c29 ph1
    cpu_addr = 13'h0000; vid_addr = 13'h0020; #1;
    step();                                   // c30 ph2 grant + sync
    vid_sync = 1'b1; #1;
    chk("sync_grant_addr", 32'(ram_addr), 32'h0000);
    step();                                   // c31 realigned ph0
    vid_sync = 1'b0; #1;
    chk("sync_ph0",      32'(dut.r_ph), 32'd0);
    chk("sync_bmp_addr", 32'(ram_addr), 32'h0020);
    chk("sync_s1_ack",   32'(cpu_ack), 32'd0);
    step(); #1;                               // c32 ph1 = S+2
    chk("sync_ack",      32'(cpu_ack), 32'd1);
    chk("sync_dout",     32'(cpu_dout), 32'hA5);
    step();                                   // c33 ph2
    cpu_req = 1'b0; #1;
    chk("sync_vga",      32'(vga_data), 32'h5A);
    step();                                   // c34 ph3
    vid_active = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 13'h0030; cpu_din = 8'h77;
`ifdef SCREEN_CONTENTION_EN
    #1;
    acks = 0; wes = 0;
    if (cpu_ack) acks++;
    if (ram_we)  wes++;
    for (int i = 0; i < 40; i++) begin
      step(); #1;
      if (cpu_ack) acks++;
      if (ram_we)  wes++;
    end
    chk("cont_acks",     32'(acks), 32'd0);
    chk("cont_writes",   32'(wes), 32'd0);
    step();                                   // ph0: release contention
    vid_active = 1'b0; #1;
    chk("cont_ph0_ack",  32'(cpu_ack), 32'd0);
    step();                                   // ph1
    step(); #1;                               // ph2 grant
    chk("cont_grant_we",   32'(ram_we), 32'd1);
    chk("cont_grant_addr", 32'(ram_addr), 32'h0030);
    step();
    step(); #1;                               // ph0 ack
    chk("cont_ack",      32'(cpu_ack), 32'd1);
`else
    #1;
    chk("nocont_grant_we",   32'(ram_we), 32'd1);
    chk("nocont_grant_addr", 32'(ram_addr), 32'h0030);
    step(); #1;
    chk("nocont_busy_we", 32'(ram_we), 32'd0);
    step(); #1;
    chk("nocont_ack",    32'(cpu_ack), 32'd1);
`endif
    step();
    cpu_req = 1'b0; vid_active = 1'b0;

    // Reset in the cycle after a read grant drops the access.
    for (int k = 0; k < 8 && tb_ph != 2'd1; k++) step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    step(); #1;                               // ph2 grant
    chk("rst_grant_addr", 32'(ram_addr), 32'h0010);
    step();                                   // S+1
    reset = 1'b1; #1;
    chk("rst_s1_ack",    32'(cpu_ack), 32'd0);
    step();
    reset = 1'b0; cpu_req = 1'b0; #1;
    chk("rst2_ph",       32'(dut.r_ph), 32'd0);
    chk("rst2_ack",      32'(cpu_ack), 32'd0);
    chk("rst2_dout",     32'(cpu_dout), 32'h00);
    chk("rst2_vga",      32'(vga_data), 32'h00);
    chk("rst2_attr",     32'(attr_data), 32'h00);
    chk("rst2_ram_we",   32'(ram_we), 32'd0);
    step(); #1;
    chk("rst2_late_ack", 32'(cpu_ack), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
